// File: rtl/mouse_pkg.sv
// Shared field positions, report layout and saturation helpers for the mouse report conditioner.
package mouse_pkg;

    localparam int TOG   = 24;
    localparam int Y_HI  = 23;
    localparam int X_HI  = 15;
    localparam int Y_OVF = 7;
    localparam int X_OVF = 6;
    localparam int Y_SGN = 5;
    localparam int X_SGN = 4;

    localparam logic signed [12:0] DELTA_MIN = -13'sd256;
    localparam logic signed [12:0] DELTA_MAX = 13'sd255;

    typedef struct packed {
        logic       tog;
        logic [7:0] y_lo;
        logic [7:0] x_lo;
        logic       y_ovf;
        logic       x_ovf;
        logic       y_sgn;
        logic       x_sgn;
        logic       rsvd;
        logic [2:0] btn;
    } mouse_rpt_t;

    function automatic logic sat_hit(input logic signed [12:0] v);
        return (v < DELTA_MIN) || (v > DELTA_MAX);
    endfunction

    function automatic logic signed [8:0] sat9(input logic signed [12:0] v);
        logic signed [8:0] r;
        if (v < DELTA_MIN) begin
            r = 9'h100;
        end else if (v > DELTA_MAX) begin
            r = 9'h0FF;
        end else begin
            r = v[8:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One axis of motion coalescing: sign-extend, optional gain, clamped add and sticky overflow.
// The gain input exists only when MOUSE_ACCUM_SPEED_EN is defined.
module mouse_axis_acc
    import mouse_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ce_i,
    input  logic              rpt_i,
    input  logic              emit_i,
    input  logic [7:0]        delta_lo_i,
    input  logic              delta_sgn_i,
    input  logic              ovf_i,
`ifdef MOUSE_ACCUM_SPEED_EN
    input  logic [1:0]        speed_i,
`endif
    output logic signed [8:0] acc_o,
    output logic              ovf_o
);

    logic signed [8:0]  acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic signed [12:0] delta_s, base_s, sum_s;

    // An emission hands the old sum out, so a same-cycle report starts from zero.
    always_comb begin
`ifdef MOUSE_ACCUM_SPEED_EN
        delta_s = {{4{delta_sgn_i}}, delta_sgn_i, delta_lo_i} <<< speed_i;
`else
        delta_s = {{4{delta_sgn_i}}, delta_sgn_i, delta_lo_i};
`endif
        base_s = emit_i ? 13'sd0 : {{4{acc_q[8]}}, acc_q};
        sum_s  = base_s + delta_s;
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        if (rpt_i) begin
            acc_d = sat9(sum_s);
            ovf_d = (emit_i ? 1'b0 : ovf_q) | sat_hit(sum_s) | ovf_i;
        end else if (emit_i) begin
            acc_d = 9'sd0;
            ovf_d = 1'b0;
        end else begin
            acc_d = acc_q;
            ovf_d = ovf_q;
        end
    end

    // Accumulator state, advanced only on enabled cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= 9'sd0;
            ovf_q <= 1'b0;
        end else if (ce_i) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/mouse_accum.sv
// Coalesces and paces toggle-strobed PS/2 mouse reports into the same 25-bit format.
// Optional MOUSE_ACCUM_SPEED_EN adds a 2-bit SPEED gain input.
module mouse_accum
    import mouse_pkg::*;
#(
    parameter logic [15:0] RATE = 16'd1000
)
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [24:0] PS2_MOUSE,
`ifdef MOUSE_ACCUM_SPEED_EN
    input  logic [1:0]  SPEED,
`endif
    output logic [24:0] MOUSE
);

    logic              prev_tog_q, prev_tog_d;
    logic              primed_q, primed_d;
    logic [15:0]       timer_q, timer_d;
    logic [2:0]        btn_q, btn_d;
    logic [2:0]        btn_out_q, btn_out_d;
    mouse_rpt_t        mouse_q, mouse_d;
    logic              rpt_s, emit_s, pending_s;
    logic signed [8:0] acc_x_s, acc_y_s;
    logic              ovf_x_s, ovf_y_s;
    logic              unused_s;

    assign unused_s = PS2_MOUSE[3];

    mouse_axis_acc u_x (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .ce_i        (CE),
        .rpt_i       (rpt_s),
        .emit_i      (emit_s),
        .delta_lo_i  (PS2_MOUSE[X_HI -: 8]),
        .delta_sgn_i (PS2_MOUSE[X_SGN]),
        .ovf_i       (PS2_MOUSE[X_OVF]),
`ifdef MOUSE_ACCUM_SPEED_EN
        .speed_i     (SPEED),
`endif
        .acc_o       (acc_x_s),
        .ovf_o       (ovf_x_s)
    );

    mouse_axis_acc u_y (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .ce_i        (CE),
        .rpt_i       (rpt_s),
        .emit_i      (emit_s),
        .delta_lo_i  (PS2_MOUSE[Y_HI -: 8]),
        .delta_sgn_i (PS2_MOUSE[Y_SGN]),
        .ovf_i       (PS2_MOUSE[Y_OVF]),
`ifdef MOUSE_ACCUM_SPEED_EN
        .speed_i     (SPEED),
`endif
        .acc_o       (acc_y_s),
        .ovf_o       (ovf_y_s)
    );

    // Report detection needs a primed toggle so the level present at reset never counts.
    always_comb begin
        rpt_s     = CE & primed_q & (PS2_MOUSE[TOG] != prev_tog_q);
        pending_s = (acc_x_s != 9'sd0) | (acc_y_s != 9'sd0) | (btn_q != btn_out_q) | ovf_x_s | ovf_y_s;
        emit_s    = CE & (timer_q == 16'd0) & pending_s;
    end

    // Next-state for toggle tracking, pacing timer, buttons and the output report.
    always_comb begin
        prev_tog_d = PS2_MOUSE[TOG];
        primed_d   = 1'b1;
        btn_d      = rpt_s ? PS2_MOUSE[2:0] : btn_q;
        btn_out_d  = btn_out_q;
        mouse_d    = mouse_q;
        if (emit_s) begin
            timer_d       = RATE - 16'd1;
            btn_out_d     = btn_q;
            mouse_d.tog   = ~mouse_q.tog;
            mouse_d.y_lo  = acc_y_s[7:0];
            mouse_d.x_lo  = acc_x_s[7:0];
            mouse_d.y_ovf = ovf_y_s;
            mouse_d.x_ovf = ovf_x_s;
            mouse_d.y_sgn = acc_y_s[8];
            mouse_d.x_sgn = acc_x_s[8];
            mouse_d.rsvd  = 1'b0;
            mouse_d.btn   = btn_q;
        end else if (timer_q != 16'd0) begin
            timer_d = timer_q - 16'd1;
        end else begin
            timer_d = timer_q;
        end
    end

    // Control and output registers; CE=0 cycles leave everything untouched.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prev_tog_q <= 1'b0;
            primed_q   <= 1'b0;
            timer_q    <= 16'd0;
            btn_q      <= 3'd0;
            btn_out_q  <= 3'd0;
            mouse_q    <= '0;
        end else if (CE) begin
            prev_tog_q <= prev_tog_d;
            primed_q   <= primed_d;
            timer_q    <= timer_d;
            btn_q      <= btn_d;
            btn_out_q  <= btn_out_d;
            mouse_q    <= mouse_d;
        end
    end

    assign MOUSE = mouse_q;

endmodule

// File: doc/mouse_accum.md
# mouse_accum

Conditions raw host PS/2 mouse reports before they reach the controller-port multiplexer's 25-bit `MOUSE` input. Reports arriving faster than the port logic consumes them are coalesced into one summed report, and the sum saturates rather than wraps. Output reports are paced to at most one per `RATE` CE cycles. Output uses the same toggle-strobed 25-bit format as the input, so it drops straight onto the multiplexer's `MOUSE` port.

## Interface
Parameters:
- `RATE`, 1000: minimum CE cycles between emitted reports (16-bit, ≥1).

Ports:
- `CLK`  in  1  system clock. One clock domain.
- `RESET`  in  1  asynchronous, active-high reset.
- `CE`  in  1  clock enable; all sampling and state updates occur only on CLK edges with CE=1.
- `PS2_MOUSE`  in  25  raw host report:
  - [24] toggle strobe
  - [23:16] Y delta low byte; [15:8] X delta low byte
  - [7] Y ovf; [6] X ovf; [5] Y sign; [4] X sign
  - [2:0] buttons M/R/L
- `MOUSE`  out  25  coalesced report in the identical format; a new report is indicated by [24] toggling.

## Operation
- Deltas are 9-bit signed: {sign, byte}, range −256..+255.
- A new input report is detected on a CE cycle where `PS2_MOUSE[24]` ≠ `prev_tog`; `prev_tog` is updated every CE.
- **Priming:** on the first CE after reset, `prev_tog` loads from the input and nothing is accumulated. A toggle level present at reset is never counted as a report.
- **Accumulation, per axis:**
  - `acc_next = acc + delta`, computed at 13 bits signed.
  - The sum is clamped to [−256, +255].
  - The axis sticky-ovf flag is set if clamping occurred or if the input ovf bit is 1.
- **Buttons:** `btn` register takes the latest report's [2:0] on every detected report.
- **Pending:** true when `acc_x≠0` OR `acc_y≠0` OR `btn≠btn_out` OR any sticky ovf is set.
- **Emission:** occurs on a CE where `timer==0` AND pending. On emission:
  - `MOUSE[24]` inverts.
  - `MOUSE[23:0]` is built from the pre-update `acc_x`, `acc_y`, sticky ovf flags and `btn`.
  - `timer` loads `RATE−1`.
  - Sticky flags clear.
- **Report and emission in the same CE:** the accumulators load the new delta alone (the old sum has been emitted), and sticky flags take only the new report's overflow. No delta is lost or double-counted.
- **Timer:** decrements on each CE while nonzero; it holds at 0 when idle.
- **Reset mid-operation:** accumulators and pending data are discarded; `MOUSE` returns to 0.

## Timing
- Reset values: `MOUSE`=25'd0, `acc_x`=`acc_y`=0, sticky flags=0, `btn`=`btn_out`=0, `timer`=0, `primed`=0, `prev_tog`=0.
- `MOUSE` is fully registered, with no combinational path from `PS2_MOUSE`.
- **Latency:** an input report sampled on CE n with the timer idle produces an output toggle on CE n+1, visible after that edge.
- **Pacing:** consecutive output toggles are at least `RATE` CE cycles apart. `RATE=1` means an emission is possible on every CE.
- Cycles with CE=0 change no state. The timer counts CE cycles, not CLK cycles.

## Configuration
- `MOUSE_ACCUM_SPEED_EN` defined:
  - adds input port `SPEED` (2 bits).
  - Each input delta is arithmetically shifted left by `SPEED` (×1/×2/×4/×8) before accumulation.
  - The 13-bit adder covers the worst case; the same clamp and ovf rules apply.
- Not defined: the `SPEED` port does not exist and the gain is fixed at ×1.

## Structure
- Package `mouse_pkg`:
  - bit-position localparams (TOG=24, Y_HI=23, X_HI=15, Y_OVF=7, X_OVF=6, Y_SGN=5, X_SGN=4).
  - typedef `mouse_rpt_t`, a packed struct for the 25-bit format.
  - constants `DELTA_MIN`=−256 and `DELTA_MAX`=255.
- Sub-module `mouse_axis_acc`, instantiated twice (X, Y). It handles sign extension, optional shift, clamped add, sticky ovf, and clear-and-load on emission.
- The top level holds toggle detection, the priming flag, the pacing timer, button tracking and output registering.

## Test plan
- Reset with input toggle=1, hold 5 CE → `MOUSE` stays 0, no toggle.
- `RATE`=4; one report X=+10, Y=−3 → on the next CE `MOUSE[24]`=1, X byte 0x0A sign 0, Y byte 0xFD sign 1, ovf bits 0.
- Three reports X=+100 within one pacing window → a single emitted report with X=+255, X ovf=1; the following emission has ovf=0.
- Report arriving on the exact emission CE → the first output carries only the old sum, the next output carries exactly the new delta; totals are conserved.
- Button L pressed with zero motion → an output report with [0]=1 and X=Y=0; RESET asserted mid-window → `MOUSE`=0 immediately (asynchronous).
- `MOUSE_ACCUM_SPEED_EN`, `SPEED`=2, delta X=−70 → X=−256 clamped, X ovf=1.
